// File: rtl/xrdarb.sv
// xrdarb: round-robin read arbiter for a shared register-file read mux.
// Requesters may hold a grant for bursts of up to MAXBURST consecutive reads
// by asserting lock while granted. Read data returns one cycle after selection.
// Optional feature macro: XRDARB_ZERO_REG_EN (reads of index 0 return zero).
module xrdarb #(
    parameter int NREQ     = 4,
    parameter int width    = 5,
    parameter int height   = 32,
    parameter int MAXBURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         lock,
    input  logic [NREQ*width-1:0]   addr,
    output logic [width-1:0]        mux_who,
    input  logic [height-1:0]       mux_val,
    output logic [NREQ-1:0]         rvalid,
    output logic [height-1:0]       rdata
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);
    localparam logic [3:0] MAXB = 4'(MAXBURST);
    // A burst limit of one makes locking meaningless, so LOCK is never entered.
    localparam bit LOCK_EN = (MAXBURST > 1);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [PW-1:0]     ptr_reg, ptr_next;
    logic [PW-1:0]     owner_reg, owner_next;
    logic [3:0]        burst_reg, burst_next;
    logic [3:0]        burst_inc;
    logic [NREQ-1:0]   rvalid_reg;
    logic [height-1:0] rdata_reg;

    logic              win_any;
    logic [PW-1:0]     win_idx;
    logic [NREQ-1:0]   win_onehot;
    logic [PW-1:0]     cand;
    int                scan_idx;
    logic [width-1:0]  addr_slice [NREQ];
    logic [height-1:0] cap_data;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    // Split the packed address bus into one select per requester and build
    // the one-hot form of the current winner.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign addr_slice[gi] = addr[gi*width +: width];
        assign win_onehot[gi] = win_any && (win_idx == PW'(gi));
    end

    // Winner selection: the lock owner only, or the first request at/after the pointer.
    always_comb begin
        win_any  = 1'b0;
        win_idx  = '0;
        scan_idx = 0;
        cand     = '0;
        if (!rst) begin
            if (state_reg == LOCK) begin
                if (req[owner_reg]) begin
                    win_any = 1'b1;
                    win_idx = owner_reg;
                end
            end else begin
                // Scan from the far end so the closest request to the pointer wins last.
                for (int o = NREQ - 1; o >= 0; o--) begin
                    scan_idx = int'(ptr_reg) + o;
                    if (scan_idx >= NREQ) begin
                        scan_idx = scan_idx - NREQ;
                    end
                    cand = PW'(scan_idx);
                    if (req[cand]) begin
                        win_any = 1'b1;
                        win_idx = cand;
                    end
                end
            end
        end
    end

    assign mux_who   = win_any ? addr_slice[win_idx] : '0;
    assign burst_inc = burst_reg + 4'd1;

    // Next arbitration state: pointer advance, burst entry, burst count and exit.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        burst_next = burst_reg;
        if (state_reg == ARB) begin
            if (win_any) begin
                ptr_next = next_idx(win_idx);
                if (LOCK_EN && lock[win_idx]) begin
                    state_next = LOCK;
                    owner_next = win_idx;
                    burst_next = 4'd1;
                end
            end
        end else begin
            if (!req[owner_reg]) begin
                // Owner went quiet: this cycle is idle and arbitration resumes after it.
                state_next = ARB;
                ptr_next   = next_idx(owner_reg);
                burst_next = 4'd0;
            end else if ((burst_inc >= MAXB) || !lock[owner_reg]) begin
                state_next = ARB;
                ptr_next   = next_idx(owner_reg);
                burst_next = 4'd0;
            end else begin
                burst_next = burst_inc;
            end
        end
    end

`ifdef XRDARB_ZERO_REG_EN
    // Index 0 is a hardwired zero register regardless of what the mux returns.
    assign cap_data = (mux_who == '0) ? '0 : mux_val;
`else
    assign cap_data = mux_val;
`endif

    // Arbitration state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ARB;
            ptr_reg   <= '0;
            owner_reg <= '0;
            burst_reg <= 4'd0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
            burst_reg <= burst_next;
        end
    end

    // Read return: one-hot valid pulse for the winner, data held when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_reg <= '0;
            rdata_reg  <= '0;
        end else begin
            rvalid_reg <= win_onehot;
            if (win_any) begin
                rdata_reg <= cap_data;
            end
        end
    end

    assign rvalid = rvalid_reg;
    assign rdata  = rdata_reg;

endmodule
